// File: rtl/ap_prof_pkg.sv
// Shared types for the ap_ctrl_hs transaction profiler.
// No logic: state encoding, record layout and default widths.
// Record layout matches the FIFO packing {id, latency, interval}.
package ap_prof_pkg;

  localparam int ID_W_DEF  = 16;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_WAIT_CONT = 2'd2
  } ap_prof_state_t;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [CNT_W_DEF-1:0] latency;
    logic [CNT_W_DEF-1:0] interval;
  } ap_prof_rec_t;

endpackage

// File: rtl/prof_rec_fifo.sv
// Record FIFO: DEPTH-entry circular buffer, head presented from flops.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push_rdy drops when full unless the head is popped that same cycle.
module prof_rec_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop_rdy && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_rdy = !full || do_pop;
  assign do_push  = push_vld && push_rdy;
  assign pop_vld  = !empty;
  assign pop_dat  = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/ap_txn_profiler.sv
// Profiles an ap_ctrl_hs module: per-transaction id, start-to-done latency and start-to-start interval.
// Latency: a record appears on rec_* one cycle after the completion (done) cycle.
// Backpressure: rec_valid/rec_ready; a completion meeting a full, non-popping FIFO is counted as a drop.
module ap_txn_profiler
  import ap_prof_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = 4,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             prof_en,
  input  logic             mon_ap_start,
  input  logic             mon_ap_done,
  input  logic             mon_ap_continue,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [ID_W-1:0]  rec_id,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  localparam int RW = ID_W + 2*CNT_W;

  ap_prof_state_t   state;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] ival_cnt;
  logic             first_txn;
  logic [ID_W-1:0]  next_id;
  logic [ID_W-1:0]  cur_id;
  logic [CNT_W-1:0] cur_ival;

  logic             start;
  logic             complete;
  logic             push_rdy;
  logic [CNT_W-1:0] ival_now;
  logic [ID_W-1:0]  push_id;
  logic [CNT_W-1:0] push_lat;
  logic [CNT_W-1:0] push_ival;
  logic [RW-1:0]    push_dat;
  logic [RW-1:0]    pop_dat;

  assign start     = (state == ST_IDLE) && prof_en && mon_ap_start;
  assign complete  = mon_ap_done && (start || (state == ST_BUSY));
  assign ival_now  = first_txn ? '0 : ival_cnt;
  // A same-cycle start/done completes from the live values, not the not-yet-written registers.
  assign push_id   = start ? next_id  : cur_id;
  assign push_lat  = start ? '0       : lat_cnt;
  assign push_ival = start ? ival_now : cur_ival;
  assign push_dat  = {push_id, push_lat, push_ival};
  assign {rec_id, rec_latency, rec_interval} = pop_dat;
  assign busy      = (state != ST_IDLE);

  // Transaction FSM: one transaction in flight; lat_cnt holds the cycles elapsed since start.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      next_id  <= '0;
      cur_id   <= '0;
      cur_ival <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            next_id  <= next_id + 1'b1;
            cur_id   <= next_id;
            cur_ival <= ival_now;
            lat_cnt  <= CNT_W'(1);
            if (mon_ap_done) state <= mon_ap_continue ? ST_IDLE : ST_WAIT_CONT;
            else             state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mon_ap_done)         state   <= mon_ap_continue ? ST_IDLE : ST_WAIT_CONT;
          else if (lat_cnt != '1)  lat_cnt <= lat_cnt + 1'b1;
        end
        ST_WAIT_CONT: begin
          if (mon_ap_continue) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Free-running start-to-start interval counter, restarted at every accepted start.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ival_cnt  <= '0;
      first_txn <= 1'b1;
    end else if (start) begin
      ival_cnt  <= CNT_W'(1);
      first_txn <= 1'b0;
    end else if (ival_cnt != '1) begin
      ival_cnt  <= ival_cnt + 1'b1;
    end
  end

  // Saturating completion and drop statistics; a dropped record still counts as a transaction.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      txn_count  <= '0;
      drop_count <= '0;
    end else if (complete) begin
      if (txn_count != '1) txn_count <= txn_count + 1'b1;
      if (!push_rdy && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

  prof_rec_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .push_vld (complete),
    .push_rdy (push_rdy),
    .push_dat (push_dat),
    .pop_vld  (rec_valid),
    .pop_rdy  (rec_ready),
    .pop_dat  (pop_dat)
  );

endmodule

// File: tb/tb_ap_txn_profiler.sv
// Bench for ap_txn_profiler: directed scenarios then random traffic.
// Expected records come from a timestamp-based model into a scoreboard queue.
// A negedge monitor compares the FIFO head and the statistics every cycle.
module tb_ap_txn_profiler;

  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int ID_W  = 4;
  localparam int SATV  = (1 << CNT_W) - 1;

  logic             ap_clk;
  logic             ap_rst_n;
  logic             prof_en;
  logic             mon_ap_start;
  logic             mon_ap_done;
  logic             mon_ap_continue;
  logic             rec_valid;
  logic             rec_ready;
  logic [ID_W-1:0]  rec_id;
  logic [CNT_W-1:0] rec_latency;
  logic [CNT_W-1:0] rec_interval;
  logic [CNT_W-1:0] txn_count;
  logic [CNT_W-1:0] drop_count;
  logic             busy;

  ap_txn_profiler #(.CNT_W(CNT_W), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .prof_en         (prof_en),
    .mon_ap_start    (mon_ap_start),
    .mon_ap_done     (mon_ap_done),
    .mon_ap_continue (mon_ap_continue),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .rec_id          (rec_id),
    .rec_latency     (rec_latency),
    .rec_interval    (rec_interval),
    .txn_count       (txn_count),
    .drop_count      (drop_count),
    .busy            (busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int id;
    int lat;
    int ival;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;

  // Reference model: transaction described by timestamps of start/done edges.
  int cyc = 0;
  bit in_flight = 0;
  bit hold_cont = 0;
  bit seen_start = 0;
  int t_start = 0;
  int last_start = 0;
  int m_next_id = 0;
  int m_occ = 0;
  int m_txn = 0;
  int m_drop = 0;
  exp_t cur;

  function automatic int sat(input int v);
    return (v > SATV) ? SATV : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge ap_clk) begin
    bit pop;
    bit fin;
    cyc++;
    if (!ap_rst_n) begin
      in_flight = 0; hold_cont = 0; seen_start = 0;
      m_next_id = 0; m_occ = 0; m_txn = 0; m_drop = 0;
      sb_q.delete();
    end else begin
      pop = rec_ready && (m_occ > 0);
      fin = 0;
      if (!in_flight && !hold_cont) begin
        if (prof_en && mon_ap_start) begin
          cur.id     = m_next_id;
          m_next_id  = (m_next_id + 1) % (1 << ID_W);
          cur.ival   = seen_start ? sat(cyc - last_start) : 0;
          seen_start = 1;
          last_start = cyc;
          t_start    = cyc;
          if (mon_ap_done) fin = 1;
          else             in_flight = 1;
        end
      end else if (in_flight) begin
        if (mon_ap_done) begin
          fin = 1;
          in_flight = 0;
        end
      end else if (mon_ap_continue) begin
        hold_cont = 0;
      end
      if (fin) begin
        cur.lat = sat(cyc - t_start);
        if (!mon_ap_continue) hold_cont = 1;
        m_txn = sat(m_txn + 1);
        if (m_occ == DEPTH && !pop) m_drop = sat(m_drop + 1);
        else begin
          sb_q.push_back(cur);
          m_occ++;
        end
      end
      if (pop) m_occ--;
    end
  end

  // Monitor: outputs after each edge are compared against the model and scoreboard head.
  always @(negedge ap_clk) begin
    if (mon_en) begin
      chk("rec_valid", {31'd0, rec_valid}, {31'd0, m_occ != 0});
      chk("busy", {31'd0, busy}, {31'd0, in_flight || hold_cont});
      chk("txn_count", 32'(txn_count), 32'(m_txn));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      if (rec_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rec_unexpected: id %0d with no record expected (t=%0t)", rec_id, $time);
        end else begin
          chk("rec_id", 32'(rec_id), 32'(sb_q[0].id));
          chk("rec_latency", 32'(rec_latency), 32'(sb_q[0].lat));
          chk("rec_interval", 32'(rec_interval), 32'(sb_q[0].ival));
          if (rec_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic s, input logic d,
                       input logic c, input logic y);
    ap_rst_n = r; prof_en = e; mon_ap_start = s; mon_ap_done = d;
    mon_ap_continue = c; rec_ready = y;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) drive(1, 1, 0, 0, 1, 1);
  endtask

  initial begin
    ap_rst_n = 0; prof_en = 0; mon_ap_start = 0; mon_ap_done = 0;
    mon_ap_continue = 1; rec_ready = 0;
    do_reset();
    mon_en = 1;
    chk("rst_rec_valid", {31'd0, rec_valid}, 32'd0);
    chk("rst_rec_id", 32'(rec_id), 32'd0);
    chk("rst_rec_latency", 32'(rec_latency), 32'd0);
    chk("rst_rec_interval", 32'(rec_interval), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Start held from cycle 10, done 5 cycles later.
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 1, 0, 1, 0);
    drive(1, 1, 1, 1, 1, 0);
    drive(1, 1, 0, 0, 1, 0);
    chk("s1_txn", 32'(txn_count), 32'd1);
    chk("s1_lat", 32'(rec_latency), 32'd5);
    chk("s1_ival", 32'(rec_interval), 32'd0);
    chk("s1_id", 32'(rec_id), 32'd0);
    drain();

    // Two same-cycle start/done transactions back to back.
    do_reset();
    drive(1, 1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 1, 0);
    drive(1, 1, 0, 0, 1, 0);
    chk("s2_txn", 32'(txn_count), 32'd2);
    chk("s2_head_lat", 32'(rec_latency), 32'd0);
    drive(1, 1, 0, 0, 1, 1);
    chk("s2_id1", 32'(rec_id), 32'd1);
    chk("s2_ival1", 32'(rec_interval), 32'd1);
    drain();

    // Done with continue low for 3 cycles, start held throughout.
    do_reset();
    drive(1, 1, 1, 0, 1, 1);
    drive(1, 1, 1, 1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 0, 0, 1);
      chk("s3_busy_wait", {31'd0, busy}, 32'd1);
      chk("s3_txn_wait", 32'(txn_count), 32'd1);
    end
    drive(1, 1, 1, 0, 1, 1);
    drive(1, 1, 1, 0, 1, 1);
    chk("s3_restart_busy", {31'd0, busy}, 32'd1);
    drive(1, 1, 0, 1, 1, 1);
    drain();

    // FIFO overflow with consumer stalled, then push+pop while full.
    do_reset();
    for (int i = 0; i < 6; i++) drive(1, 1, 1, 1, 1, 0);
    drive(1, 1, 0, 0, 1, 0);
    chk("s4_drop", 32'(drop_count), 32'd2);
    chk("s4_txn", 32'(txn_count), 32'd6);
    chk("s4_head", 32'(rec_id), 32'd0);
    drive(1, 1, 1, 1, 1, 1);
    chk("s5_drop", 32'(drop_count), 32'd2);
    chk("s5_head", 32'(rec_id), 32'd1);
    drain();

    // Reset mid-transaction at latency 7.
    do_reset();
    drive(1, 1, 0, 0, 1, 1);
    drive(1, 1, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++) drive(1, 1, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 1, 1);
    chk("s6_busy", {31'd0, busy}, 32'd0);
    chk("s6_txn", 32'(txn_count), 32'd0);
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 1, 1, 1, 1, 0);
    drive(1, 1, 0, 0, 1, 0);
    chk("s6_id", 32'(rec_id), 32'd0);
    chk("s6_ival", 32'(rec_interval), 32'd0);
    drain();

    // Latency and interval saturation.
    do_reset();
    drive(1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 300; i++) drive(1, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 1, 0);
    drive(1, 1, 0, 0, 1, 0);
    chk("sat_lat", 32'(rec_latency), SATV);
    drive(1, 1, 1, 1, 1, 1);
    drain();

    // Random traffic, including occasional resets and id wrap.
    for (int i = 0; i < 4000; i++)
      drive(($urandom % 400) != 0, ($urandom % 8) != 0, ($urandom % 2) == 0,
            ($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 2) == 0);
    drive(1, 0, 0, 0, 1, 1);
    drain();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
